// File: rtl/pipeline_pkg.sv
// Shared constants for the 5-stage pipeline hazard controller: forwarding
// select encodings and the register-index width helper.
package pipeline_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Never returns 0 so a degenerate NREG still gives a legal vector width.
   function automatic int calc_aw(input int nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the CPU datapath (master) and the hazard controller
// (slave): register indices, write qualifiers, stall/flush/forward controls.
interface pipeline_hazard_ctrl_if #(
   parameter int NREG  = 32,
   parameter int CNT_W = 32
);
   import pipeline_pkg::*;

   localparam int AW = calc_aw(NREG);

   logic [AW-1:0]    id_rs1;
   logic [AW-1:0]    id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [AW-1:0]    ex_rs1;
   logic [AW-1:0]    ex_rs2;
   logic [AW-1:0]    idex_rd;
   logic [AW-1:0]    exmem_rd;
   logic [AW-1:0]    memwb_rd;
   logic             idex_regwrite;
   logic             exmem_regwrite;
   logic             memwb_regwrite;
   logic             idex_memread;
   logic             mem_pcsrc;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_bubble;
   logic             flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             v_ifid;
   logic             v_idex;
   logic             v_exmem;
   logic             v_memwb;
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] ret_cnt;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2,
             idex_rd, exmem_rd, memwb_rd,
             idex_regwrite, exmem_regwrite, memwb_regwrite,
             idex_memread, mem_pcsrc,
      input  pc_en, ifid_en, idex_bubble, flush, fwd_a, fwd_b,
             v_ifid, v_idex, v_exmem, v_memwb,
             cyc_cnt, stall_cnt, flush_cnt, ret_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2,
             idex_rd, exmem_rd, memwb_rd,
             idex_regwrite, exmem_regwrite, memwb_regwrite,
             idex_memread, mem_pcsrc,
      output pc_en, ifid_en, idex_bubble, flush, fwd_a, fwd_b,
             v_ifid, v_idex, v_exmem, v_memwb,
             cyc_cnt, stall_cnt, flush_cnt, ret_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// Free-running performance counters (cycles, stalls, flushes, retirements);
// only instantiated when PIPE_PERF_CNT_EN is defined. All counters wrap.
module hazard_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_stall,
   input  logic             inc_flush,
   input  logic             inc_ret,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] ret_cnt
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_cnt   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         ret_cnt   <= '0;
      end else begin
         cyc_cnt   <= cyc_cnt   + CNT_W'(1);
         stall_cnt <= stall_cnt + CNT_W'(inc_stall);
         flush_cnt <= flush_cnt + CNT_W'(inc_flush);
         ret_cnt   <= ret_cnt   + CNT_W'(inc_ret);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and stage-valid controller for the IF/ID/EX/MEM/WB pipeline.
// Define PIPE_PERF_CNT_EN to build the performance counters; otherwise they read 0.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int NREG  = 32,
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int AW = calc_aw(NREG);

   logic v_ifid;
   logic v_idex;
   logic v_exmem;
   logic v_memwb;
   logic wr_mem;
   logic wr_wb;
   logic br;
   logic lu;

   assign wr_mem = v_exmem && hz.exmem_regwrite && (hz.exmem_rd != '0);
   assign wr_wb  = v_memwb && hz.memwb_regwrite && (hz.memwb_rd != '0);

   assign br = hz.mem_pcsrc && v_exmem;
   assign lu = v_idex && hz.idex_memread && (hz.idex_rd != '0) && v_ifid &&
               ((hz.id_use_rs1 && (hz.id_rs1 == hz.idex_rd)) ||
                (hz.id_use_rs2 && (hz.id_rs2 == hz.idex_rd)));

   // A taken branch overrides the load-use stall: the stalled instruction is squashed anyway.
   assign hz.flush       = br;
   assign hz.idex_bubble = lu && !br;
   assign hz.pc_en       = !(lu && !br);
   assign hz.ifid_en     = !(lu && !br);

   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                          input logic          ex_valid,
                                          input logic          mem_wr,
                                          input logic [AW-1:0] mem_rd,
                                          input logic          wb_wr,
                                          input logic [AW-1:0] wb_rd);
      logic [1:0] sel;
      sel = FWD_RF;
      if (ex_valid && (rs != '0)) begin
         if (mem_wr && (mem_rd == rs))
            sel = FWD_MEM;
         else if (wb_wr && (wb_rd == rs))
            sel = FWD_WB;
      end
      return sel;
   endfunction

   assign hz.fwd_a = fwd_sel(hz.ex_rs1, v_idex, wr_mem, hz.exmem_rd, wr_wb, hz.memwb_rd);
   assign hz.fwd_b = fwd_sel(hz.ex_rs2, v_idex, wr_mem, hz.exmem_rd, wr_wb, hz.memwb_rd);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_ifid  <= 1'b0;
         v_idex  <= 1'b0;
         v_exmem <= 1'b0;
         v_memwb <= 1'b0;
      end else begin
         v_ifid  <= br ? 1'b0 : (lu ? v_ifid : 1'b1);
         v_idex  <= (br || lu) ? 1'b0 : v_ifid;
         v_exmem <= br ? 1'b0 : v_idex;
         v_memwb <= v_exmem;
      end
   end

   assign hz.v_ifid  = v_ifid;
   assign hz.v_idex  = v_idex;
   assign hz.v_exmem = v_exmem;
   assign hz.v_memwb = v_memwb;

`ifdef PIPE_PERF_CNT_EN
   hazard_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc_stall (lu && !br),
      .inc_flush (br),
      .inc_ret   (v_memwb),
      .cyc_cnt   (hz.cyc_cnt),
      .stall_cnt (hz.stall_cnt),
      .flush_cnt (hz.flush_cnt),
      .ret_cnt   (hz.ret_cnt)
   );
`else
   assign hz.cyc_cnt   = {CNT_W{1'b0}};
   assign hz.stall_cnt = {CNT_W{1'b0}};
   assign hz.flush_cnt = {CNT_W{1'b0}};
   assign hz.ret_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a stage-list
// reference model of valid bits, stalls, flushes, forwarding and counters.
module tb_pipeline_hazard_ctrl;
   import pipeline_pkg::*;

   logic clk;
   logic reset;

   int n_assert;
   int n_fail;

   pipeline_hazard_ctrl_if #(.NREG(32), .CNT_W(32)) bus ();

   pipeline_hazard_ctrl #(.NREG(32), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: occupancy of the four pipeline registers, index 0 = IF/ID ... 3 = MEM/WB.
   bit [3:0]    mv;
   logic [31:0] m_cyc, m_stall, m_flush, m_ret;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_br();
      return bus.mem_pcsrc && mv[2];
   endfunction

   function automatic bit m_lu();
      bit hit;
      hit = (bus.id_use_rs1 && bus.id_rs1 == bus.idex_rd) ||
            (bus.id_use_rs2 && bus.id_rs2 == bus.idex_rd);
      return mv[1] && mv[0] && bus.idex_memread && bus.idex_rd != 0 && hit;
   endfunction

   // Younger producer (EX/MEM) is searched first; register 0 never forwards.
   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (!mv[1] || rs == 0) return FWD_RF;
      if (mv[2] && bus.exmem_regwrite && bus.exmem_rd == rs) return FWD_MEM;
      if (mv[3] && bus.memwb_regwrite && bus.memwb_rd == rs) return FWD_WB;
      return FWD_RF;
   endfunction

   task automatic check_comb();
      bit stall;
      stall = m_lu() && !m_br();
      chk("flush",       bus.flush,       m_br());
      chk("pc_en",       bus.pc_en,       !stall);
      chk("ifid_en",     bus.ifid_en,     !stall);
      chk("idex_bubble", bus.idex_bubble, stall);
      chk("fwd_a",       bus.fwd_a,       m_fwd(bus.ex_rs1));
      chk("fwd_b",       bus.fwd_b,       m_fwd(bus.ex_rs2));
   endtask

   task automatic check_regs();
      chk("v_ifid",    bus.v_ifid,    mv[0]);
      chk("v_idex",    bus.v_idex,    mv[1]);
      chk("v_exmem",   bus.v_exmem,   mv[2]);
      chk("v_memwb",   bus.v_memwb,   mv[3]);
      chk("cyc_cnt",   bus.cyc_cnt,   m_cyc);
      chk("stall_cnt", bus.stall_cnt, m_stall);
      chk("flush_cnt", bus.flush_cnt, m_flush);
      chk("ret_cnt",   bus.ret_cnt,   m_ret);
   endtask

   task automatic model_reset();
      mv = 4'b0000;
      m_cyc = 0; m_stall = 0; m_flush = 0; m_ret = 0;
   endtask

   task automatic idle_inputs();
      bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
      bus.ex_rs1 = 0; bus.ex_rs2 = 0;
      bus.idex_rd = 0; bus.exmem_rd = 0; bus.memwb_rd = 0;
      bus.idex_regwrite = 0; bus.exmem_regwrite = 0; bus.memwb_regwrite = 0;
      bus.idex_memread = 0; bus.mem_pcsrc = 0;
   endtask

   // One clock: check combinational outputs, advance the model across the edge, check registers.
   task automatic tick();
      bit br_m, lu_m;
      bit [3:0] nv;
      #1;
      check_comb();
      br_m = m_br();
      lu_m = m_lu();
      @(posedge clk);
      #1;
      nv[0] = br_m ? 1'b0 : (lu_m ? mv[0] : 1'b1);
      nv[1] = (br_m || lu_m) ? 1'b0 : mv[0];
      nv[2] = br_m ? 1'b0 : mv[1];
      nv[3] = mv[2];
`ifdef PIPE_PERF_CNT_EN
      m_cyc   = m_cyc + 1;
      m_stall = m_stall + ((lu_m && !br_m) ? 1 : 0);
      m_flush = m_flush + (br_m ? 1 : 0);
      m_ret   = m_ret + (mv[3] ? 1 : 0);
`endif
      mv = nv;
      check_regs();
   endtask

   task automatic set_load_use();
      bus.idex_memread = 1; bus.idex_regwrite = 1; bus.idex_rd = 5'd5;
      bus.id_use_rs2 = 1; bus.id_rs2 = 5'd5;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      model_reset();
      idle_inputs();

      // Reset state
      reset = 1'b1;
      #2;
      check_regs();
      check_comb();
      chk("reset_pc_en", bus.pc_en, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Fill from empty
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 1) chk("fill_v_ifid_e1", bus.v_ifid, 1);
         if (i == 4) chk("fill_v_memwb_e4", bus.v_memwb, 1);
      end

      // Load-use on rs2: one stall cycle, then MEM/WB forwarding
      set_load_use();
      #1;
      chk("lu_pc_en", bus.pc_en, 0);
      chk("lu_bubble", bus.idex_bubble, 1);
      tick();
      idle_inputs();
      bus.id_use_rs2 = 1; bus.id_rs2 = 5'd5;
      bus.exmem_rd = 5'd5; bus.exmem_regwrite = 1;
      #1;
      chk("lu_one_cycle", bus.pc_en, 1);
      tick();
      idle_inputs();
      bus.ex_rs2 = 5'd5;
      bus.memwb_rd = 5'd5; bus.memwb_regwrite = 1;
      #1;
      chk("lu_fwd_b_wb", bus.fwd_b, FWD_WB);
      tick();
      idle_inputs();
      tick();
      tick();

      // EX/MEM beats MEM/WB; x0 never forwards
      bus.ex_rs1 = 5'd3;
      bus.exmem_rd = 5'd3; bus.exmem_regwrite = 1;
      bus.memwb_rd = 5'd3; bus.memwb_regwrite = 1;
      #1;
      chk("fwd_a_mem_prio", bus.fwd_a, FWD_MEM);
      bus.exmem_rd = 5'd0; bus.ex_rs1 = 5'd0;
      #1;
      chk("fwd_a_x0", bus.fwd_a, FWD_RF);
      tick();
      idle_inputs();

      // Taken branch together with load-use
      set_load_use();
      bus.mem_pcsrc = 1;
      #1;
      chk("br_flush", bus.flush, 1);
      chk("br_pc_en", bus.pc_en, 1);
      chk("br_no_bubble", bus.idex_bubble, 0);
      tick();
      chk("br_valids", {bus.v_ifid, bus.v_idex, bus.v_exmem, bus.v_memwb}, 4'b0001);

      // Branch request with empty EX/MEM is ignored
      idle_inputs();
      bus.mem_pcsrc = 1;
      #1;
      chk("br_ignored", bus.flush, 0);
      tick();
      idle_inputs();
      for (int i = 0; i < 4; i++) tick();

      // Asynchronous reset in the middle of a stall
      set_load_use();
      #1;
      chk("pre_reset_stall", bus.pc_en, 0);
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      chk("async_v", {bus.v_ifid, bus.v_idex, bus.v_exmem, bus.v_memwb}, 4'b0000);
      chk("async_pc_en", bus.pc_en, 1);
      chk("async_cyc", bus.cyc_cnt, 0);
      chk("async_ret", bus.ret_cnt, 0);
      check_comb();
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();

      // Randomized traffic on a small register range to provoke collisions
      for (int i = 0; i < 400; i++) begin
         bus.id_rs1 = 5'($urandom_range(0, 3));
         bus.id_rs2 = 5'($urandom_range(0, 3));
         bus.id_use_rs1 = 1'($urandom_range(0, 1));
         bus.id_use_rs2 = 1'($urandom_range(0, 1));
         bus.ex_rs1 = 5'($urandom_range(0, 3));
         bus.ex_rs2 = 5'($urandom_range(0, 3));
         bus.idex_rd = 5'($urandom_range(0, 3));
         bus.exmem_rd = 5'($urandom_range(0, 3));
         bus.memwb_rd = 5'($urandom_range(0, 3));
         bus.idex_regwrite = 1'($urandom_range(0, 1));
         bus.exmem_regwrite = 1'($urandom_range(0, 1));
         bus.memwb_regwrite = 1'($urandom_range(0, 1));
         bus.idex_memread = 1'($urandom_range(0, 1));
         bus.mem_pcsrc = ($urandom_range(0, 7) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
